// File: rtl/music_pkg.sv
// Shared constants for the music player: song entry layout, pitch codes,
// note frequency table and sequencer state encoding.
package music_pkg;

  localparam int unsigned NumTones = 21;

  localparam logic [4:0] PitchRest = 5'd0;
  localparam logic [4:0] PitchEnd  = 5'd31;

  localparam int unsigned PitchMsb = 7;
  localparam int unsigned PitchLsb = 3;
  localparam int unsigned DurMsb   = 2;
  localparam int unsigned DurLsb   = 0;

  // C4..B4, C5..B5, C6..B6 in Hz, indexed by pitch-1
  localparam int unsigned NoteHz [NumTones] = '{
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988,
    1047, 1175, 1319, 1397, 1568, 1760, 1976
  };

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StLoad   = 3'd2;
  localparam logic [2:0] StSound  = 3'd3;
  localparam logic [2:0] StGap    = 3'd4;
  localparam logic [2:0] StPaused = 3'd5;

  typedef logic [NumTones-1:0][31:0] half_tab_t;

  function automatic half_tab_t half_table(input int unsigned clk_hz);
    half_tab_t tab;
    for (int i = 0; i < NumTones; i++) begin
      tab[i] = clk_hz / (2 * NoteHz[i]);
    end
    return tab;
  endfunction

  function automatic logic is_tone(input logic [4:0] pitch);
    return (pitch != PitchRest) && (pitch <= 5'(NumTones));
  endfunction

  function automatic logic is_active(input logic [2:0] st);
    return (st == StFetch) || (st == StLoad) || (st == StSound) || (st == StGap);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles the output every half_period_i enabled cycles,
// first toggle half_period_i cycles after enable rises; cleared while disabled.
module tone_gen (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] half_period_i,
  input  logic        enable_i,
  output logic        buzzer_o
);

  logic [31:0] cnt_q, cnt_d;
  logic        buzzer_q, buzzer_d;

  // enable_i is driven from the sequencer's next state, so the count starts on the
  // edge that enters SOUND; hence the compare against half_period_i rather than -1.
  always_comb begin
    cnt_d    = cnt_q;
    buzzer_d = buzzer_q;
    if (!enable_i) begin
      cnt_d    = 32'd0;
      buzzer_d = 1'b0;
    end else if (cnt_q == half_period_i) begin
      cnt_d    = 32'd1;
      buzzer_d = ~buzzer_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= 32'd0;
      buzzer_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign buzzer_o = buzzer_q;

endmodule

// File: rtl/music_sequencer.sv
// Song ROM walker: times notes and inter-note gaps, handles play/pause/next/prev,
// drives the buzzer through tone_gen and the 24-bit status LED bank.
module music_sequencer
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_i,
  input  logic              next_i,
  input  logic              prev_i,
  input  logic [7:0]        note_data,
  output logic [ADDR_W-1:0] note_addr,
  output logic              buzzer,
  output logic              playing,
  output logic [23:0]       led
);

  localparam half_tab_t         HalfTab = half_table(CLK_HZ);
  localparam logic [ADDR_W-1:0] AddrOne = 1;

  logic [2:0]        state_q, state_d;
  logic [2:0]        saved_q, saved_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       dur_q, dur_d;
  logic [31:0]       gap_q, gap_d;
  logic [4:0]        pitch_q, pitch_d;
  logic [31:0]       hp_q, hp_d;
  logic              playing_q, playing_d;
  logic [23:0]       led_q, led_d;
  logic              tone_en;

  logic [4:0] rom_pitch;
  logic [2:0] rom_dur;

  assign rom_pitch = note_data[PitchMsb:PitchLsb];
  assign rom_dur   = note_data[DurMsb:DurLsb];

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    addr_d  = addr_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    pitch_d = pitch_q;
    hp_d    = hp_q;

    unique case (state_q)
      StIdle: if (play_i) state_d = StFetch;
      StFetch: state_d = StLoad;
      StLoad: begin
        if (rom_pitch == PitchEnd) begin
          addr_d  = '0;
          state_d = StIdle;
        end else begin
          pitch_d = rom_pitch;
          hp_d    = is_tone(rom_pitch) ? HalfTab[rom_pitch - 5'd1] : 32'd0;
          dur_d   = (32'(rom_dur) + 32'd1) * BEAT_CYCLES - 32'd1;
          state_d = StSound;
        end
      end
      StSound: begin
        if (dur_q == 32'd0) begin
          gap_d   = 32'(GAP_CYCLES) - 32'd1;
          state_d = StGap;
        end else begin
          dur_d = dur_q - 32'd1;
        end
      end
      StGap: begin
        if (gap_q == 32'd0) begin
          addr_d  = addr_q + AddrOne;
          state_d = StFetch;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      StPaused: if (play_i) state_d = saved_q;
      default: state_d = StIdle;
    endcase

    // Navigation overrides normal progression; a pause still lets the current
    // cycle count, so the saved state is the one we would have moved to.
    if (next_i || prev_i) begin
      if (next_i) begin
        addr_d = addr_q + AddrOne;
      end else begin
        addr_d = (addr_q == '0) ? '0 : addr_q - AddrOne;
      end
      dur_d = 32'd0;
      gap_d = 32'd0;
      if (is_active(state_q)) begin
        state_d = StFetch;
      end else begin
        state_d = state_q;
        if (state_q == StPaused) saved_d = StFetch;
      end
    end else if (play_i && is_active(state_q) && (state_d != StIdle)) begin
      saved_d = state_d;
      state_d = StPaused;
    end
  end

  always_comb begin
    tone_en   = (state_d == StSound) && is_tone(pitch_d);
    playing_d = is_active(state_d);
    led_d     = '0;
    if (tone_en) led_d[pitch_d - 5'd1] = 1'b1;
    led_d[21] = (state_d == StGap);
    led_d[22] = (state_d == StPaused);
    led_d[23] = playing_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      saved_q   <= StIdle;
      addr_q    <= '0;
      dur_q     <= 32'd0;
      gap_q     <= 32'd0;
      pitch_q   <= 5'd0;
      hp_q      <= 32'd0;
      playing_q <= 1'b0;
      led_q     <= 24'd0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      addr_q    <= addr_d;
      dur_q     <= dur_d;
      gap_q     <= gap_d;
      pitch_q   <= pitch_d;
      hp_q      <= hp_d;
      playing_q <= playing_d;
      led_q     <= led_d;
    end
  end

  tone_gen u_tone_gen (
    .clk_i         (clk),
    .rst_ni        (rst),
    .half_period_i (hp_d),
    .enable_i      (tone_en),
    .buzzer_o      (buzzer)
  );

  assign note_addr = addr_q;
  assign playing   = playing_q;
  assign led       = led_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: random songs checked against a timeline model of
// note/gap timing, plus directed pause, navigation, wrap and reset scenarios.
module tb_music_sequencer;

  localparam int ClkHz = 100_000;
  localparam int Beat  = 16;
  localparam int Gap   = 4;
  localparam int AddrW = 6;

  logic             clk, rst, play_i, next_i, prev_i;
  logic [7:0]       note_data;
  logic [AddrW-1:0] note_addr;
  logic             buzzer, playing;
  logic [23:0]      led;

  logic [7:0] rom [64];
  int n_tests = 0;
  int n_fail  = 0;
  int freq [21] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988,
                    1047, 1175, 1319, 1397, 1568, 1760, 1976};

  music_sequencer #(
    .CLK_HZ      (ClkHz),
    .BEAT_CYCLES (Beat),
    .GAP_CYCLES  (Gap),
    .ADDR_W      (AddrW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .play_i    (play_i),
    .next_i    (next_i),
    .prev_i    (prev_i),
    .note_data (note_data),
    .note_addr (note_addr),
    .buzzer    (buzzer),
    .playing   (playing),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) note_data <= rom[note_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle c = 0 is the first FETCH cycle of entry 'start'.
  function automatic void model(input int start, input int c, output logic [5:0] e_addr,
                                output logic e_buz, output logic e_play,
                                output logic [23:0] e_led);
    int pos, idx, p, n, off;
    pos = 0;
    idx = start;
    e_addr = '0;
    e_buz = 1'b0;
    e_play = 1'b0;
    e_led = '0;
    for (int guard = 0; guard < 4096; guard++) begin
      p = int'(rom[idx][7:3]);
      if (p == 31) begin
        if (c == pos || c == pos + 1) begin
          e_addr = 6'(idx);
          e_play = 1'b1;
          e_led[23] = 1'b1;
        end
        return;
      end
      n = (int'(rom[idx][2:0]) + 1) * Beat;
      if (c < pos + n + Gap + 2) begin
        off = c - pos;
        e_addr = 6'(idx);
        e_play = 1'b1;
        e_led[23] = 1'b1;
        if (off >= 2 && off < 2 + n) begin
          if (p >= 1 && p <= 21) begin
            e_buz = (((off - 2) / (ClkHz / (2 * freq[p-1]))) % 2) == 1;
            e_led[p-1] = 1'b1;
          end
        end else if (off >= 2 + n) begin
          e_led[21] = 1'b1;
        end
        return;
      end
      pos += n + Gap + 2;
      idx = (idx + 1) % 64;
    end
  endfunction

  function automatic int total_len(input int start);
    int t, idx;
    t = 0;
    idx = start;
    for (int guard = 0; guard < 64; guard++) begin
      if (rom[idx][7:3] == 5'd31) return t + 2;
      t += (int'(rom[idx][2:0]) + 1) * Beat + Gap + 2;
      idx = (idx + 1) % 64;
    end
    return t;
  endfunction

  task automatic start_play();
    @(negedge clk);
    play_i = 1'b1;
    @(posedge clk);
    #1 play_i = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] m);
    @(negedge clk);
    {play_i, prev_i, next_i} = m;
    @(posedge clk);
    #1 {play_i, prev_i, next_i} = 3'b000;
    @(negedge clk);
  endtask

  // Compare every cycle against the model; optionally fire a button mask at nav_at.
  task automatic run(input int start, input int max_c, input int nav_at, input logic [2:0] nav);
    logic [5:0] ea;
    logic eb, ep;
    logic [23:0] el;
    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      model(start, c, ea, eb, ep, el);
      check_eq($sformatf("addr@%0d", c), 32'(note_addr), 32'(ea));
      check_eq($sformatf("buzzer@%0d", c), 32'(buzzer), 32'(eb));
      check_eq($sformatf("playing@%0d", c), 32'(playing), 32'(ep));
      check_eq($sformatf("led@%0d", c), 32'(led), 32'(el));
      if (c == nav_at) begin
        {play_i, prev_i, next_i} = nav;
        @(posedge clk);
        #1 {play_i, prev_i, next_i} = 3'b000;
        return;
      end
    end
  endtask

  initial begin
    int cnt, exp_addr, len;
    rst = 1'b0;
    {play_i, prev_i, next_i} = 3'b000;
    for (int i = 0; i < 64; i++) rom[i] = 8'hF8;
    repeat (2) @(negedge clk);
    check_eq("rst_addr", 32'(note_addr), 32'd0);
    check_eq("rst_buzzer", 32'(buzzer), 32'd0);
    check_eq("rst_playing", 32'(playing), 32'd0);
    check_eq("rst_led", 32'(led), 32'd0);
    rst = 1'b1;

    // Single A4 note, two beats, then end mark
    rom[0] = {5'd6, 3'd1};
    rom[1] = 8'hF8;
    start_play();
    run(0, total_len(0) + 3, -1, 3'b000);

    // Random short songs
    repeat (4) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) rom[i] = {5'($urandom_range(0, 30)), 3'($urandom_range(0, 2))};
      rom[len] = 8'hF8;
      start_play();
      run(0, total_len(0) + 3, -1, 3'b000);
    end

    // Rest and reserved pitch codes
    rom[0] = {5'd25, 3'd7};
    rom[1] = {5'd0, 3'd7};
    rom[2] = 8'hF8;
    start_play();
    run(0, total_len(0) + 3, -1, 3'b000);

    // Navigation while playing: next, prev, then next+prev+play together
    for (int i = 0; i < 10; i++) rom[i] = {5'($urandom_range(1, 21)), 3'd0};
    rom[10] = 8'hF8;
    start_play();
    run(0, 100, 30, 3'b001);
    run(2, 100, 25, 3'b010);
    run(2, 100, 10, 3'b111);
    run(3, total_len(3) + 3, -1, 3'b000);

    // Pause after 10 SOUND cycles, hold 50, resume
    rom[0] = {5'd6, 3'd1};
    rom[1] = 8'hF8;
    start_play();
    run(0, 12, 11, 3'b100);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("pause_buzzer", 32'(buzzer), 32'd0);
      check_eq("pause_led", 32'(led), 32'h400000);
      if (i == 49) begin
        play_i = 1'b1;
        @(posedge clk);
        #1 play_i = 1'b0;
      end
    end
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (led[5]) cnt++;
      else break;
    end
    check_eq("resume_sound_cycles", 32'(cnt), 32'd22);
    check_eq("resume_gap_led", 32'(led), 32'hA00000);
    repeat (6) @(negedge clk);
    check_eq("pause_end_playing", 32'(playing), 32'd0);
    check_eq("pause_end_addr", 32'(note_addr), 32'd0);

    // Navigation in IDLE
    pulse(3'b010);
    check_eq("prev_at_0", 32'(note_addr), 32'd0);
    repeat (63) pulse(3'b001);
    check_eq("next_to_63", 32'(note_addr), 32'd63);
    pulse(3'b001);
    check_eq("next_wrap", 32'(note_addr), 32'd0);
    exp_addr = 0;
    repeat (40) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse(3'b001);
        exp_addr = (exp_addr + 1) % 64;
      end else begin
        pulse(3'b010);
        exp_addr = (exp_addr == 0) ? 0 : exp_addr - 1;
      end
      check_eq("rand_nav", 32'(note_addr), 32'(exp_addr));
    end
    pulse(3'b111);
    check_eq("triple_addr", 32'(note_addr), 32'((exp_addr + 1) % 64));
    repeat (2) @(negedge clk);
    check_eq("triple_playing", 32'(playing), 32'd0);
    check_eq("triple_led", 32'(led), 32'd0);
    repeat (64) pulse(3'b010);
    check_eq("back_to_0", 32'(note_addr), 32'd0);

    // Full wrap with 64 playable entries, then asynchronous reset mid-SOUND
    for (int i = 0; i < 64; i++) rom[i] = {5'($urandom_range(0, 30)), 3'd0};
    start_play();
    run(0, 1501, -1, 3'b000);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_addr", 32'(note_addr), 32'd0);
    check_eq("async_rst_buzzer", 32'(buzzer), 32'd0);
    check_eq("async_rst_playing", 32'(playing), 32'd0);
    check_eq("async_rst_led", 32'(led), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_playing", 32'(playing), 32'd0);
      check_eq("post_rst_addr", 32'(note_addr), 32'd0);
      check_eq("post_rst_led", 32'(led), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
Controller that sequences the buzzer tone datapath of the music player. Walks a synchronous song ROM (one note entry per address), times each note and the inter-note gap, and generates the square-wave buzzer drive. Accepts play/pause, next and previous pulses from the upstream debounced-button logic. Drives the 24-bit LED bank with the current note and status, and sits directly below the board top level beside the ROM.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; half-period table computed from it at elaboration
BEAT_CYCLES, 12_500_000, clock cycles per beat (125 ms)
GAP_CYCLES, 1_000_000, silent cycles between notes
ADDR_W, 6, ROM address width; song length 2**ADDR_W entries

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
play_i  input  1  single-cycle pulse; toggles play/pause
next_i  input  1  single-cycle pulse; skip to next entry
prev_i  input  1  single-cycle pulse; back one entry
note_data  input  8  ROM data, valid one cycle after note_addr
note_addr  output  ADDR_W  ROM address
buzzer  output  1  square-wave tone drive
playing  output  1  high in FETCH/LOAD/SOUND/GAP
led  output  24  note/status display

Behaviour:
- Entry encoding: [7:3] pitch, [2:0] dur. Pitch 0 = rest; 1..7 = C4..B4, 8..14 = C5..B5, 15..21 = C6..B6; 22..30 = rest; 31 = end-of-song. Note length = (dur+1)*BEAT_CYCLES cycles.
- Reset (rst=0, asynchronous): state IDLE, note_addr=0, all counters 0, buzzer=0, playing=0, led=0.
- States: IDLE, FETCH, LOAD, SOUND, GAP, PAUSED.
- IDLE: play_i -> FETCH.
- FETCH: note_addr stable, 1 cycle -> LOAD.
- LOAD: latch note_data. Pitch 31 -> note_addr=0, IDLE. Otherwise load the duration counter and the half-period counter, then -> SOUND.
- SOUND: duration counter decrements each cycle. At terminal count -> GAP.
- GAP: buzzer=0 for GAP_CYCLES cycles. Then note_addr increments (wraps 2**ADDR_W-1 -> 0) and -> FETCH.
- Per-note period: (dur+1)*BEAT_CYCLES + GAP_CYCLES + 2 cycles.
- Tone generation: in SOUND with pitch 1..21, buzzer toggles every HALF_PERIOD[pitch] cycles, where HALF_PERIOD[pitch] = floor(CLK_HZ/(2*freq)). The first toggle occurs HALF_PERIOD cycles after entering SOUND, starting from buzzer=0. For rest pitches, buzzer is held 0.
- Pause/resume: play_i in FETCH/LOAD/SOUND/GAP -> PAUSED. In PAUSED, all counters freeze and buzzer=0. play_i in PAUSED returns to the saved state with the remaining count intact.
- next_i in any state: note_addr+1 (wrapping), counters clear. Playing states -> FETCH; IDLE/PAUSED keep their state.
- prev_i: note_addr-1, saturating at 0. Otherwise handled exactly like next_i.
- Simultaneous pulses: priority is next_i > prev_i > play_i. Lower-priority pulses in the same cycle are ignored.
- LED mapping: led[pitch-1] is one-hot in SOUND for pitch 1..21; led[21]=GAP; led[22]=PAUSED; led[23]=playing.
- All outputs are registered.

Decomposition:
- Shared package music_pkg: pitch code constants (REST, END_MARK=31), the 21-entry note frequency table in Hz, the state enum, and entry field positions.
- Sub-module tone_gen: inputs half_period and enable; output buzzer. Contains the half-period counter and toggle flop; clears when enable is low.
- Sequencer FSM, duration/gap counters and LED decode stay in music_sequencer.

Test Plan:
All scenarios use CLK_HZ=100_000, BEAT_CYCLES=16, GAP_CYCLES=4, and a 1-cycle-latency ROM model.
1. Reset under activity: assert rst=0 mid-SOUND -> all outputs 0 in the same cycle; after release the block stays IDLE with note_addr=0.
2. Single note: ROM[0]=A4 (pitch 6, dur 1), then ROM[1]=31. Pulse play -> buzzer toggles every 113 cycles for 32 SOUND cycles and led[5]=1. Then 4 GAP cycles with led[21]=1, then the end marker -> IDLE, playing=0, note_addr=0.
3. Pause/resume: pause 10 cycles into SOUND, hold 50 cycles -> buzzer=0 and led[22]=1 throughout. Resume -> exactly 22 SOUND cycles remain.
4. Rest and reserved codes: pitch 0 or 25 with dur 7 -> buzzer stays 0 for 128 cycles, led[20:0]=0, playing=1.
5. Navigation: prev at addr 0 -> stays 0. next at addr 63 -> 0. next+prev+play in the same cycle -> only next takes effect.
6. Full wrap: fill ROM with 64 non-end notes -> note_addr wraps 63->0 and playback continues without stopping.
